// File: rtl/wfg_run_controller.sv
// Purpose: Wishbone-master sequencer that enables the waveform core, counts sync periods, then disables it.
// Latency: bus cycle starts the cycle after start_i or after the terminating sync edge / stop_i; done_o one cycle after disable ack.
// Backpressure: waits on wbm_ack_i for every write; abandons the access after ACK_TIMEOUT cycles and flags err_o.
module wfg_run_controller #(
    parameter int              BUSW        = 32,
    parameter logic [BUSW-1:0] CTRL_ADR    = 32'h0000_0000,
    parameter logic [BUSW-1:0] EN_VAL      = 32'h0000_0001,
    parameter int              CNTW        = 16,
    parameter int              ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic [CNTW-1:0] run_len_i,
    input  logic            wfg_core_sync_i,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [3:0]      wbm_sel_o,
    output logic [BUSW-1:0] wbm_adr_o,
    output logic [BUSW-1:0] wbm_dat_o,
    input  logic            wbm_ack_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [CNTW-1:0] periods_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_EN  = 2'd1,
        ST_RUN    = 2'd2,
        ST_WR_DIS = 2'd3
    } state_t;

    // The timeout counter holds the number of elapsed un-acked strobe cycles;
    // the access is abandoned on the edge that would complete the last one.
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t          r_state;
    logic [CNTW-1:0] r_run_len;
    logic [CNTW-1:0] r_periods;
    logic            r_pend_stop;
    logic            r_sync_q;
    logic [7:0]      r_to_cnt;
    logic            r_cyc;
    logic [3:0]      r_sel;
    logic [BUSW-1:0] r_adr;
    logic [BUSW-1:0] r_dat;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_sync_rise;
    logic [CNTW-1:0] w_periods_inc;
    logic            w_to_expire;
    logic            w_target_hit;

    assign w_sync_rise   = wfg_core_sync_i & ~r_sync_q;
    assign w_periods_inc = r_periods + CNTW'(1);
    assign w_to_expire   = (r_to_cnt == TO_LAST);
    assign w_target_hit  = w_sync_rise && (r_run_len != '0) && (w_periods_inc == r_run_len);

    // cyc, stb and we always move together, so one flop drives all three
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_cyc;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign periods_o = r_periods;

    // Previous sync level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_q <= 1'b0;
        end else begin
            r_sync_q <= wfg_core_sync_i;
        end
    end

    // Sequencer FSM with registered bus and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_run_len   <= '0;
            r_periods   <= '0;
            r_pend_stop <= 1'b0;
            r_to_cnt    <= '0;
            r_cyc       <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state     <= ST_WR_EN;
                        r_run_len   <= run_len_i;
                        r_periods   <= '0;
                        r_err       <= 1'b0;
                        r_pend_stop <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cyc       <= 1'b1;
                        r_sel       <= 4'hF;
                        r_adr       <= CTRL_ADR;
                        r_dat       <= EN_VAL;
                        r_to_cnt    <= '0;
                    end
                end

                ST_WR_EN: begin
                    if (stop_i) begin
                        r_pend_stop <= 1'b1;
                    end
                    // ack wins over a timeout expiring on the same edge
                    if (wbm_ack_i) begin
                        r_cyc <= 1'b0;
                        r_sel <= '0;
                        r_adr <= '0;
                        r_dat <= '0;
                        // leaving cyc low here gives the idle bus cycle before the disable write
                        r_state <= (r_pend_stop || stop_i) ? ST_WR_DIS : ST_RUN;
                    end else if (w_to_expire) begin
                        r_cyc   <= 1'b0;
                        r_sel   <= '0;
                        r_adr   <= '0;
                        r_dat   <= '0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end

                ST_RUN: begin
                    if (w_sync_rise) begin
                        r_periods <= w_periods_inc;
                    end
                    if (w_target_hit || stop_i) begin
                        r_state  <= ST_WR_DIS;
                        r_cyc    <= 1'b1;
                        r_sel    <= 4'hF;
                        r_adr    <= CTRL_ADR;
                        r_dat    <= '0;
                        r_to_cnt <= '0;
                    end
                end

                ST_WR_DIS: begin
                    if (!r_cyc) begin
                        // arrived straight from an enable ack: start the write now
                        r_cyc    <= 1'b1;
                        r_sel    <= 4'hF;
                        r_adr    <= CTRL_ADR;
                        r_dat    <= '0;
                        r_to_cnt <= '0;
                    end else if (wbm_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_sel   <= '0;
                        r_adr   <= '0;
                        r_dat   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_to_expire) begin
                        r_cyc   <= 1'b0;
                        r_sel   <= '0;
                        r_adr   <= '0;
                        r_dat   <= '0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wfg_run_controller.sv
// Purpose: directed checks of the run controller against hand-computed expectations.
// Latency: responder acks after a programmable number of strobe cycles.
// Backpressure: responder can withhold ack entirely to exercise the timeout.
module tb_wfg_run_controller;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        stop_i;
    logic [15:0] run_len_i;
    logic        sync_i;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic        busy, done, err;
    logic [15:0] periods;

    int n_tests = 0;
    int n_fail  = 0;

    // bus responder state / monitors
    int          ack_dly = 1;
    logic        ack_en  = 1'b1;
    int          ack_cnt = 0;
    int          wr_cnt  = 0;
    int          done_cnt = 0;
    int          b2b_cnt = 0;
    logic [31:0] last_dat = '0;
    logic [31:0] last_adr = '0;

    int d0, w0, n;

    wfg_run_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .run_len_i       (run_len_i),
        .wfg_core_sync_i (sync_i),
        .wbm_cyc_o       (cyc),
        .wbm_stb_o       (stb),
        .wbm_we_o        (we),
        .wbm_sel_o       (sel),
        .wbm_adr_o       (adr),
        .wbm_dat_o       (dat),
        .wbm_ack_i       (ack),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .periods_o       (periods)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Wishbone slave model plus done/back-to-back monitors, evaluated at negedge
    initial begin
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack && stb) b2b_cnt++;
            if (done) done_cnt++;
            if (stb && !ack && ack_en) begin
                ack_cnt++;
                if (ack_cnt >= ack_dly) begin
                    ack      = 1'b1;
                    wr_cnt++;
                    last_dat = dat;
                    last_adr = adr;
                end
            end else begin
                ack     = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    task automatic do_start(input logic [15:0] len);
        @(negedge clk);
        start_i   = 1'b1;
        run_len_i = len;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
    endtask

    task automatic sync_pulse();
        repeat (2) @(negedge clk);
        sync_i = 1'b1;
        @(negedge clk);
        sync_i = 1'b0;
    endtask

    task automatic wait_stb(input logic v, input string tag);
        int k;
        k = 0;
        while (stb !== v && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(stb), 32'(v));
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; run_len_i = '0; sync_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(cyc), 32'h0);
        chk("rst_stb", 32'(stb), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_periods", 32'(periods), 32'h0);
        chk("rst_adr_dat", adr | dat, 32'h0);
        rst_n = 1'b1;

        // run_len=3, ack after 2 cycles, 4 sync pulses
        ack_dly = 2; d0 = done_cnt; w0 = wr_cnt;
        do_start(16'd3);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_stb", 32'({cyc, stb, we}), 32'h7);
        chk("t1_sel", 32'(sel), 32'hF);
        chk("t1_adr", adr, 32'h0);
        chk("t1_dat", dat, 32'h1);
        wait_stb(1'b0, "t1_en_done");
        chk("t1_en_wr", 32'(wr_cnt - w0), 32'd1);
        chk("t1_en_dat", last_dat, 32'h1);
        sync_pulse();
        sync_pulse();
        chk("t1_p2", 32'(periods), 32'd2);
        chk("t1_p2_nostb", 32'(stb), 32'h0);
        sync_pulse();
        chk("t1_p3", 32'(periods), 32'd3);
        chk("t1_dis_stb", 32'(stb), 32'h1);
        chk("t1_dis_dat", dat, 32'h0);
        sync_pulse();
        wait_idle("t1_idle");
        chk("t1_pfinal", 32'(periods), 32'd3);
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_wr", 32'(wr_cnt - w0), 32'd2);
        chk("t1_lastdat", last_dat, 32'h0);
        chk("t1_lastadr", last_adr, 32'h0);

        // continuous mode, 5 pulses, then stop
        ack_dly = 1; d0 = done_cnt; w0 = wr_cnt;
        do_start(16'd0);
        wait_stb(1'b0, "t2_en_done");
        for (int i = 0; i < 5; i++) sync_pulse();
        chk("t2_run_busy", 32'(busy), 32'h1);
        do_stop();
        wait_idle("t2_idle");
        chk("t2_periods", 32'(periods), 32'd5);
        chk("t2_done", 32'(done_cnt - d0), 32'd1);
        chk("t2_wr", 32'(wr_cnt - w0), 32'd2);
        chk("t2_lastdat", last_dat, 32'h0);

        // stop during the enable write (ack delayed 4 cycles)
        ack_dly = 4; d0 = done_cnt; w0 = wr_cnt;
        do_start(16'd5);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        wait_idle("t3_idle");
        chk("t3_periods", 32'(periods), 32'd0);
        chk("t3_wr", 32'(wr_cnt - w0), 32'd2);
        chk("t3_lastdat", last_dat, 32'h0);
        chk("t3_done", 32'(done_cnt - d0), 32'd1);
        chk("t3_err", 32'(err), 32'h0);

        // no ack: timeout after 15 strobe cycles
        ack_en = 1'b0; d0 = done_cnt; w0 = wr_cnt;
        do_start(16'd2);
        n = 0;
        while (stb === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t4_stb_cycles", 32'(n), 32'd15);
        chk("t4_err", 32'(err), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t4_no_dis", 32'(stb), 32'h0);
        ack_en = 1'b1;
        do_start(16'd1);
        chk("t4_err_clr", 32'(err), 32'h0);
        wait_stb(1'b0, "t4_en_done");
        sync_pulse();
        wait_idle("t4_idle");
        chk("t4_periods", 32'(periods), 32'd1);

        // sync edge and stop in the same RUN cycle
        d0 = done_cnt;
        do_start(16'd10);
        wait_stb(1'b0, "t5_en_done");
        sync_pulse();
        sync_pulse();
        repeat (2) @(negedge clk);
        sync_i = 1'b1;
        stop_i = 1'b1;
        @(negedge clk);
        sync_i = 1'b0;
        stop_i = 1'b0;
        chk("t5_periods", 32'(periods), 32'd3);
        chk("t5_dis_stb", 32'(stb), 32'h1);
        chk("t5_dis_dat", dat, 32'h0);
        wait_idle("t5_idle");
        chk("t5_done", 32'(done_cnt - d0), 32'd1);

        // asynchronous reset during the disable write
        ack_dly = 8;
        do_start(16'd0);
        wait_stb(1'b0, "t6_en_done");
        do_stop();
        wait_stb(1'b1, "t6_dis_stb");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cyc", 32'(cyc), 32'h0);
        chk("t6_rst_stb", 32'(stb), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_dly = 1; d0 = done_cnt; w0 = wr_cnt;
        do_start(16'd2);
        chk("t6_restart", 32'(busy), 32'h1);
        wait_stb(1'b0, "t6_en_done2");
        sync_pulse();
        sync_pulse();
        wait_idle("t6_idle");
        chk("t6_periods", 32'(periods), 32'd2);
        chk("t6_done", 32'(done_cnt - d0), 32'd1);
        chk("t6_wr", 32'(wr_cnt - w0), 32'd2);

        chk("no_b2b", 32'(b2b_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
